alu_cmd_ctrl: RTL and testbench



---
 rtl/alu_cmd_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_alu_cmd_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_ctrl.sv
// Command-side ALU controller: assembles A/B/FUN from RX bytes, runs one ALU op, streams the result to TX LSB first.
// Optional FUN validation is compiled in with `define ALU_CMD_CHECK_EN.
module alu_cmd_ctrl #(
   parameter int OP_WIDTH = 8,
   parameter int TIMEOUT  = 4
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [7:0]              RX_P_DATA,
   input  logic                    RX_D_VLD,
   output logic [OP_WIDTH-1:0]     ALU_A,
   output logic [OP_WIDTH-1:0]     ALU_B,
   output logic [3:0]              ALU_FUN,
   output logic                    ALU_EN,
   input  logic [2*OP_WIDTH-1:0]   ALU_OUT,
   input  logic                    ALU_OUT_VLD,
   output logic [7:0]              TX_P_DATA,
   output logic                    TX_VALID,
   input  logic                    TX_READY,
   output logic                    BUSY,
   output logic                    DROP_ERR,
   output logic                    TIMEOUT_ERR
);

   localparam int NB = OP_WIDTH / 8;
   localparam int RB = 2 * NB;
   localparam int RW = 2 * OP_WIDTH;
   localparam logic [1:0] LAST_OP  = 2'(NB - 1);
   localparam logic [1:0] LAST_RES = 2'(RB - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GET_B,
      S_GET_FUN,
      S_ALU_REQ,
      S_ALU_WAIT,
      S_SEND
   } state_t;

   state_t              r_state;
   logic [1:0]          r_cnt;
   logic [3:0]          r_wait;
   logic [OP_WIDTH-1:0] r_a;
   logic [OP_WIDTH-1:0] r_b;
   logic [3:0]          r_fun;
   logic                r_en;
   logic [RW-1:0]       r_result;
   logic [7:0]          r_tx_data;
   logic                r_tx_valid;
   logic                r_drop;
   logic                r_tmo;

   logic [OP_WIDTH-1:0] w_a_next;
   logic [OP_WIDTH-1:0] w_b_next;
   logic [1:0]          w_cnt_inc;
   logic [7:0]          w_next_byte;
   logic                w_fun_bad;
   logic                w_wait_expired;

   // Byte-lane insertion of the incoming RX byte at the current counter position.
   for (genvar gi = 0; gi < NB; gi++) begin : g_op_lane
      assign w_a_next[gi*8 +: 8] = (r_cnt == 2'(gi)) ? RX_P_DATA : r_a[gi*8 +: 8];
      assign w_b_next[gi*8 +: 8] = (r_cnt == 2'(gi)) ? RX_P_DATA : r_b[gi*8 +: 8];
   end

   assign w_cnt_inc = 2'(r_cnt + 2'd1);

   always_comb begin
      w_next_byte = '0;
      for (int i = 0; i < RB; i++) begin
         if (w_cnt_inc == 2'(i)) begin
            w_next_byte = r_result[i*8 +: 8];
         end
      end
   end

`ifdef ALU_CMD_CHECK_EN
   assign w_fun_bad = (RX_P_DATA[7:4] != 4'h0) || (RX_P_DATA[3:0] == 4'hF);
`else
   assign w_fun_bad = 1'b0;
`endif

   // r_wait counts ALU_WAIT cycles from 0; the first wait cycle is already one cycle after ALU_EN.
   assign w_wait_expired = ({1'b0, r_wait} + 5'd2) >= 5'(TIMEOUT);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_wait     <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_fun      <= '0;
         r_en       <= 1'b0;
         r_result   <= '0;
         r_tx_data  <= '0;
         r_tx_valid <= 1'b0;
         r_drop     <= 1'b0;
         r_tmo      <= 1'b0;
      end else begin
         r_en   <= 1'b0;
         r_drop <= 1'b0;
         r_tmo  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (RX_D_VLD) begin
                  r_a <= w_a_next;
                  if (r_cnt == LAST_OP) begin
                     r_cnt   <= '0;
                     r_state <= S_GET_B;
                  end else begin
                     r_cnt <= w_cnt_inc;
                  end
               end
            end
            S_GET_B: begin
               if (RX_D_VLD) begin
                  r_b <= w_b_next;
                  if (r_cnt == LAST_OP) begin
                     r_cnt   <= '0;
                     r_state <= S_GET_FUN;
                  end else begin
                     r_cnt <= w_cnt_inc;
                  end
               end
            end
            S_GET_FUN: begin
               if (RX_D_VLD) begin
                  if (w_fun_bad) begin
                     r_result   <= {RB{8'hEE}};
                     r_tx_data  <= 8'hEE;
                     r_tx_valid <= 1'b1;
                     r_cnt      <= '0;
                     r_state    <= S_SEND;
                  end else begin
                     r_fun   <= RX_P_DATA[3:0];
                     r_en    <= 1'b1;
                     r_state <= S_ALU_REQ;
                  end
               end
            end
            S_ALU_REQ: begin
               r_drop  <= RX_D_VLD;
               r_wait  <= '0;
               r_state <= S_ALU_WAIT;
            end
            S_ALU_WAIT: begin
               r_drop <= RX_D_VLD;
               if (ALU_OUT_VLD) begin
                  r_result   <= ALU_OUT;
                  r_tx_data  <= ALU_OUT[7:0];
                  r_tx_valid <= 1'b1;
                  r_cnt      <= '0;
                  r_state    <= S_SEND;
               end else if (w_wait_expired) begin
                  r_result   <= '1;
                  r_tx_data  <= 8'hFF;
                  r_tx_valid <= 1'b1;
                  r_tmo      <= 1'b1;
                  r_cnt      <= '0;
                  r_state    <= S_SEND;
               end else begin
                  r_wait <= 4'(r_wait + 4'd1);
               end
            end
            S_SEND: begin
               r_drop <= RX_D_VLD;
               if (TX_READY) begin
                  if (r_cnt == LAST_RES) begin
                     r_tx_valid <= 1'b0;
                     r_tx_data  <= '0;
                     r_cnt      <= '0;
                     r_state    <= S_IDLE;
                  end else begin
                     r_cnt     <= w_cnt_inc;
                     r_tx_data <= w_next_byte;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign ALU_A       = r_a;
   assign ALU_B       = r_b;
   assign ALU_FUN     = r_fun;
   assign ALU_EN      = r_en;
   assign TX_P_DATA   = r_tx_data;
   assign TX_VALID    = r_tx_valid;
   assign DROP_ERR    = r_drop;
   assign TIMEOUT_ERR = r_tmo;
   assign BUSY        = (r_state != S_IDLE) || (r_cnt != 2'd0);

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Randomized bench for alu_cmd_ctrl: frame-level reference model of timing, result bytes and error pulses.
module tb_alu_cmd_ctrl;

   localparam int OW  = 8;
   localparam int TMO = 4;
   localparam int NB  = OW / 8;
   localparam int RB  = 2 * NB;
   localparam int RW  = 2 * OW;

   logic          CLK;
   logic          RST;
   logic [7:0]    RX_P_DATA;
   logic          RX_D_VLD;
   logic [OW-1:0] ALU_A;
   logic [OW-1:0] ALU_B;
   logic [3:0]    ALU_FUN;
   logic          ALU_EN;
   logic [RW-1:0] ALU_OUT;
   logic          ALU_OUT_VLD;
   logic [7:0]    TX_P_DATA;
   logic          TX_VALID;
   logic          TX_READY;
   logic          BUSY;
   logic          DROP_ERR;
   logic          TIMEOUT_ERR;

   int n_total = 0;
   int n_bad   = 0;

   alu_cmd_ctrl #(.OP_WIDTH(OW), .TIMEOUT(TMO)) u_dut (
      .CLK         (CLK),
      .RST         (RST),
      .RX_P_DATA   (RX_P_DATA),
      .RX_D_VLD    (RX_D_VLD),
      .ALU_A       (ALU_A),
      .ALU_B       (ALU_B),
      .ALU_FUN     (ALU_FUN),
      .ALU_EN      (ALU_EN),
      .ALU_OUT     (ALU_OUT),
      .ALU_OUT_VLD (ALU_OUT_VLD),
      .TX_P_DATA   (TX_P_DATA),
      .TX_VALID    (TX_VALID),
      .TX_READY    (TX_READY),
      .BUSY        (BUSY),
      .DROP_ERR    (DROP_ERR),
      .TIMEOUT_ERR (TIMEOUT_ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Environment ALU behaviour (what the external ALU would compute).
   function automatic logic [RW-1:0] alu_ref(input logic [OW-1:0] a, input logic [OW-1:0] b,
                                             input logic [3:0] fun);
      case (fun)
         4'd0:    return RW'(a) + RW'(b);
         4'd1:    return RW'(a) - RW'(b);
         4'd2:    return RW'(a) * RW'(b);
         default: return RW'(a ^ b);
      endcase
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] d, input int gap);
      for (int g = 0; g < gap; g++) begin
         RX_D_VLD    = 1'b0;
         ALU_OUT_VLD = 1'($urandom_range(0, 1));
         ALU_OUT     = RW'($urandom);
         tick();
         check("drop_err_rx", DROP_ERR, 0);
      end
      RX_D_VLD    = 1'b1;
      RX_P_DATA   = d;
      ALU_OUT_VLD = 1'($urandom_range(0, 1));
      ALU_OUT     = RW'($urandom);
      tick();
      RX_D_VLD    = 1'b0;
      ALU_OUT_VLD = 1'b0;
      check("drop_err_rx", DROP_ERR, 0);
   endtask

   // lat: ALU response delay in cycles after ALU_EN; 0 means the ALU never answers.
   task automatic run_frame(input logic [OW-1:0] a, input logic [OW-1:0] b, input logic [7:0] fun,
                            input int lat, input int rdy_pct, input int drop_pct,
                            input bit rst_in_send, input int max_gap);
      logic [RW-1:0] exp_res;
      logic [RW-1:0] alu_val;
      bit   reject;
      bit   resp;
      bit   drop;
      int   first_c;
      int   idx;
      int   drop_prev;
      int   c;

      check("busy_start", BUSY, 0);
      for (int i = 0; i < NB; i++) send_byte(a[i*8 +: 8], $urandom_range(0, max_gap));
      for (int i = 0; i < NB; i++) send_byte(b[i*8 +: 8], $urandom_range(0, max_gap));
      send_byte(fun, $urandom_range(0, max_gap));

`ifdef ALU_CMD_CHECK_EN
      reject = (fun[7:4] != 4'h0) || (fun[3:0] == 4'hF);
`else
      reject = 1'b0;
`endif
      alu_val = alu_ref(a, b, fun[3:0]);
      resp    = !reject && (lat >= 1) && (lat <= TMO - 1);
      exp_res = reject ? {RB{8'hEE}} : (resp ? alu_val : {RW{1'b1}});
      first_c = reject ? 0 : (resp ? lat + 1 : TMO);

      if (!reject) begin
         check("alu_a", ALU_A, a);
         check("alu_b", ALU_B, b);
         check("alu_fun", ALU_FUN, fun[3:0]);
      end

      idx       = 0;
      drop_prev = 0;
      for (c = 0; c < 300; c++) begin
         check("alu_en", ALU_EN, (c == 0) && !reject);
         check("timeout_err", TIMEOUT_ERR, !reject && !resp && (c == TMO));
         check("drop_err", DROP_ERR, drop_prev);
         if (idx == RB) begin
            check("tx_valid_end", TX_VALID, 0);
            check("busy_end", BUSY, 0);
            break;
         end
         check("tx_valid", TX_VALID, c >= first_c);
         check("busy", BUSY, 1);
         if (c >= first_c) begin
            check("tx_data", TX_P_DATA, exp_res[idx*8 +: 8]);
            if (rst_in_send) begin
               RX_D_VLD    = 1'b0;
               ALU_OUT_VLD = 1'b0;
               #2;
               RST = 1'b1;
               #1;
               check("rst_send_tx_valid", TX_VALID, 0);
               check("rst_send_tx_data", TX_P_DATA, 0);
               check("rst_send_busy", BUSY, 0);
               @(posedge CLK);
               #1;
               RST = 1'b0;
               $display("frame a=%0h b=%0h fun=%0h reset during send", a, b, fun);
               return;
            end
         end
         ALU_OUT_VLD = resp && (c == lat);
         ALU_OUT     = (resp && (c == lat)) ? alu_val : RW'($urandom);
         TX_READY    = ($urandom_range(0, 99) < rdy_pct);
         drop        = ($urandom_range(0, 99) < drop_pct);
         RX_D_VLD    = drop;
         if (drop) RX_P_DATA = 8'($urandom);
         if ((c >= first_c) && TX_READY) idx++;
         drop_prev = drop ? 1 : 0;
         tick();
         RX_D_VLD    = 1'b0;
         ALU_OUT_VLD = 1'b0;
      end
      if (c >= 300) check("cycle_budget", 0, 1);
      $display("frame a=%0h b=%0h fun=%0h lat=%0d result=%0h cycles=%0d", a, b, fun, lat, exp_res, c);
   endtask

   initial begin
      RST         = 1'b1;
      RX_P_DATA   = '0;
      RX_D_VLD    = 1'b0;
      ALU_OUT     = '0;
      ALU_OUT_VLD = 1'b0;
      TX_READY    = 1'b1;
      #1;
      check("rst_busy", BUSY, 0);
      check("rst_tx_valid", TX_VALID, 0);
      check("rst_tx_data", TX_P_DATA, 0);
      check("rst_alu_en", ALU_EN, 0);
      check("rst_alu_a", ALU_A, 0);
      check("rst_alu_b", ALU_B, 0);
      check("rst_alu_fun", ALU_FUN, 0);
      check("rst_drop", DROP_ERR, 0);
      check("rst_tmo", TIMEOUT_ERR, 0);
      tick();
      tick();
      RST = 1'b0;

      // Basic multiply, backpressure, timeout, drop during SEND, follow-up add.
      run_frame(OW'(8'h0C), OW'(8'h05), 8'h02, 1, 100, 0, 1'b0, 0);
      run_frame(OW'(8'h0C), OW'(8'h05), 8'h02, 1, 30, 0, 1'b0, 0);
      run_frame(OW'(8'h0C), OW'(8'h05), 8'h02, 0, 100, 0, 1'b0, 0);
      run_frame(OW'(8'h0C), OW'(8'h05), 8'h02, 1, 60, 50, 1'b0, 0);
      run_frame(OW'(8'h03), OW'(8'h04), 8'h00, 1, 100, 0, 1'b0, 0);
      run_frame(OW'(8'h0C), OW'(8'h05), 8'h1F, 1, 100, 0, 1'b0, 0);
      run_frame(OW'(8'h21), OW'(8'h13), 8'h01, TMO - 1, 100, 0, 1'b0, 1);

      // Reset with A and B held but no FUN yet.
      for (int i = 0; i < NB; i++) send_byte(8'h10, 0);
      for (int i = 0; i < NB; i++) send_byte(8'h20, 0);
      check("mid_busy", BUSY, 1);
      #2;
      RST = 1'b1;
      #1;
      check("mid_rst_busy", BUSY, 0);
      check("mid_rst_alu_a", ALU_A, 0);
      check("mid_rst_alu_b", ALU_B, 0);
      check("mid_rst_tx_valid", TX_VALID, 0);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      $display("reset mid-frame after A=10 B=20");
      run_frame(OW'(8'h01), OW'(8'h01), 8'h00, 1, 100, 0, 1'b0, 0);

      for (int n = 0; n < 40; n++) begin
         logic [OW-1:0] ra;
         logic [OW-1:0] rb;
         logic [7:0]    rf;
         ra = OW'($urandom);
         rb = OW'($urandom);
         rf = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
         run_frame(ra, rb, rf, $urandom_range(0, TMO - 1), $urandom_range(30, 100),
                   $urandom_range(0, 40), ($urandom_range(0, 9) == 0), 2);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
